// File: rtl/clk_divider_bank.sv
// Bank of NCH 50%-duty clock dividers with glitch-free half-period reload.
// Optional DIVIDER_TICK_EN adds a registered pulse on each output rise.
module clk_divider_bank #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 24,
  parameter int DIV_INIT = 50000,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             IN_clk,
  input  logic             IN_rst_n,
  input  logic [NCH-1:0]   IN_en,
  input  logic             IN_sync,
  input  logic             IN_cfg_valid,
  input  logic [CH_W-1:0]  IN_cfg_ch,
  input  logic [CNT_W-1:0] IN_cfg_half,
  output logic             OUT_cfg_ready,
  output logic [NCH-1:0]   OUT_clk,
  output logic [NCH-1:0]   OUT_tick
);

  typedef enum logic {S_IDLE, S_PEND} st_e;

  st_e              r_st     [NCH];
  st_e              w_st_nx  [NCH];
  logic [CNT_W-1:0] r_cnt    [NCH];
  logic [CNT_W-1:0] w_cnt_nx [NCH];
  logic [CNT_W-1:0] r_half   [NCH];
  logic [CNT_W-1:0] w_half_nx[NCH];
  logic [CNT_W-1:0] r_pval   [NCH];
  logic [CNT_W-1:0] w_pval_nx[NCH];
  logic [NCH-1:0]   r_clk;
  logic [NCH-1:0]   w_clk_nx;
  logic [NCH-1:0]   w_pend;
  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_run;
  logic [NCH-1:0]   w_apl;
  logic             w_ch_ok;

  assign w_ch_ok = (32'(IN_cfg_ch) < 32'(NCH));

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_pend[i] = (r_st[i] == S_PEND);
    end
  end

  // Out-of-range channel: always ready, write silently dropped
  assign OUT_cfg_ready = w_ch_ok ? ~w_pend[IN_cfg_ch] : 1'b1;

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IN_cfg_valid && w_ch_ok && OUT_cfg_ready &&
          (32'(IN_cfg_ch) == 32'(i)))
        w_wr[i] = 1'b1;
    end
  end

  always_comb begin
    w_clk_nx = r_clk;
    w_run    = '0;
    w_apl    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_st_nx[i]   = r_st[i];
      w_cnt_nx[i]  = r_cnt[i];
      w_half_nx[i] = r_half[i];
      w_pval_nx[i] = r_pval[i];
      w_run[i]     = IN_en[i] && (r_half[i] != '0);
      if (IN_sync) begin
        w_cnt_nx[i] = '0;
        w_clk_nx[i] = 1'b0;
        w_st_nx[i]  = S_IDLE;
        if (w_wr[i])
          w_half_nx[i] = IN_cfg_half;
        else if (w_pend[i])
          w_half_nx[i] = r_pval[i];
      end else begin
        if (w_run[i]) begin
          if (r_cnt[i] == r_half[i] - CNT_W'(1)) begin
            w_cnt_nx[i] = '0;
            w_clk_nx[i] = ~r_clk[i];
            w_apl[i]    = w_pend[i];
          end else begin
            w_cnt_nx[i] = r_cnt[i] + CNT_W'(1);
          end
        end else begin
          if (r_half[i] == '0) begin
            w_cnt_nx[i] = '0;
            w_clk_nx[i] = 1'b0;
          end
          w_apl[i] = w_pend[i];
        end
        // Reload restarts the count so a smaller half never overruns
        if (w_apl[i]) begin
          w_half_nx[i] = r_pval[i];
          w_cnt_nx[i]  = '0;
          w_st_nx[i]   = S_IDLE;
        end
        if (w_wr[i]) begin
          w_pval_nx[i] = IN_cfg_half;
          w_st_nx[i]   = S_PEND;
        end
      end
    end
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      r_clk <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_st[i]   <= S_IDLE;
        r_cnt[i]  <= '0;
        r_half[i] <= CNT_W'(DIV_INIT);
        r_pval[i] <= '0;
      end
    end else begin
      r_clk <= w_clk_nx;
      for (int i = 0; i < NCH; i++) begin
        r_st[i]   <= w_st_nx[i];
        r_cnt[i]  <= w_cnt_nx[i];
        r_half[i] <= w_half_nx[i];
        r_pval[i] <= w_pval_nx[i];
      end
    end
  end

  assign OUT_clk = r_clk;

`ifdef DIVIDER_TICK_EN
  logic [NCH-1:0] r_tick;

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n)
      r_tick <= '0;
    else
      r_tick <= w_clk_nx & ~r_clk;
  end

  assign OUT_tick = r_tick;
`else
  assign OUT_tick = '0;
`endif

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank (NCH=4, CNT_W=8, DIV_INIT=5).
// Tick expectations follow DIVIDER_TICK_EN.
module tb_clk_divider_bank;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

`ifdef DIVIDER_TICK_EN
  localparam logic [3:0] TK_ALL = 4'hF;
  localparam int         TK_N   = 2;
`else
  localparam logic [3:0] TK_ALL = 4'h0;
  localparam int         TK_N   = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic             sync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             ready;
  logic [NCH-1:0]   oclk;
  logic [NCH-1:0]   otick;

  int n_chk = 0;
  int n_err = 0;
  int n;
  int tk;

  clk_divider_bank #(
    .NCH(NCH), .CNT_W(CNT_W), .DIV_INIT(5)
  ) dut (
    .IN_clk(clk),
    .IN_rst_n(rst_n),
    .IN_en(en),
    .IN_sync(sync),
    .IN_cfg_valid(cfg_valid),
    .IN_cfg_ch(cfg_ch),
    .IN_cfg_half(cfg_half),
    .OUT_cfg_ready(ready),
    .OUT_clk(oclk),
    .OUT_tick(otick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lvl(input int ch, input logic lvl,
                          output int cnt);
    cnt = -1;
    for (int k = 1; k <= 200 && cnt < 0; k++) begin
      step();
      if (oclk[ch] === lvl) cnt = k;
    end
  endtask

  task automatic wr(input logic [1:0] ch,
                    input logic [CNT_W-1:0] h);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = h;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("rst_clk", 32'(oclk), 0);
    check("rst_tick", 32'(otick), 0);
    check("rst_rdy", 32'(ready), 1);

    en    = 4'hF;
    rst_n = 1'b1;
    wait_lvl(0, 1'b1, n);
    check("first_rise", n, 5);
    check("all_rise", 32'(oclk), 32'hF);
    check("tick_rise", 32'(otick), 32'(TK_ALL));
    wait_lvl(0, 1'b0, n);
    check("hi_phase", n, 5);
    wait_lvl(0, 1'b1, n);
    check("lo_phase", n, 5);

    // reload ch1 to 3 while running at 5
    cfg_ch = 2'd1;
    #1 check("rdy_idle", 32'(ready), 1);
    wr(2'd1, 8'd3);
    check("tick_once", 32'(otick), 0);
    #1 check("rdy_pend", 32'(ready), 0);
    cfg_valid = 1'b1;
    cfg_half  = 8'd7;
    #1 check("rdy_rej", 32'(ready), 0);
    step();
    cfg_valid = 1'b0;
    wr(2'd2, 8'd2);
    #1 check("rdy_ch2", 32'(ready), 0);
    wait_lvl(1, 1'b0, n);
    check("old_hi_rest", n, 2);
    wait_lvl(1, 1'b1, n);
    check("new_lo", n, 3);
    wait_lvl(1, 1'b0, n);
    check("new_hi", n, 3);
    check("mix_vec", 32'(oclk), 32'b1101);
    cfg_ch = 2'd1;
    #1 check("rdy_back", 32'(ready), 1);

    // sync applies pending and same-cycle writes
    wr(2'd0, 8'd4);
    wr(2'd1, 8'd6);
    sync      = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_half  = 8'd3;
    step();
    sync      = 1'b0;
    cfg_valid = 1'b0;
    check("sync_low", 32'(oclk), 0);
    #1 check("sync_rdy", 32'(ready), 1);
    wait_lvl(2, 1'b1, n);
    check("sync_ch2", n, 2);
    wait_lvl(3, 1'b1, n);
    check("sync_ch3", n, 1);
    wait_lvl(0, 1'b1, n);
    check("sync_ch0", n, 1);
    wait_lvl(1, 1'b1, n);
    check("sync_ch1", n, 2);

    // freeze ch1 just after its rise
    en = 4'b1101;
    repeat (7) step();
    check("frz_clk", 32'(oclk[1]), 1);
    en = 4'hF;
    wait_lvl(1, 1'b0, n);
    check("frz_resume", n, 6);

    // half=0 stops ch3 low
    wr(2'd3, 8'd0);
    repeat (8) step();
    check("zero_low", 32'(oclk[3]), 0);
    wr(2'd3, 8'd2);
    wait_lvl(3, 1'b1, n);
    check("zero_restart", n, 3);

    // reset while a write is pending
    wr(2'd0, 8'd9);
    #1 check("pend0_rdy", 32'(ready), 0);
    #2 rst_n = 1'b0;
    #1 check("arst_clk", 32'(oclk), 0);
    check("arst_rdy", 32'(ready), 1);
    step();
    rst_n = 1'b1;
    wait_lvl(0, 1'b1, n);
    check("post_rst_rise", n, 5);
    wait_lvl(0, 1'b0, n);
    check("post_rst_hi", n, 5);

    tk = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (otick[0] === 1'b1) tk++;
    end
    check("tick_cnt", tk, TK_N);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
